// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core -- shared rv32 core types used by the memory stage.
//   word_t       32-bit machine word
//   mem_op_t     LOAD / STORE
//   mem_width_t  BYTE / HALF / WORD access width
//   lsu_cause_t  fault cause reported by the load/store unit
//   is_aligned() natural-alignment test for an access width
// ----------------------------------------------------------------------------
package core;

   typedef logic [31:0] word_t;

   typedef enum logic [0:0] {
      LOAD  = 1'b0,
      STORE = 1'b1
   } mem_op_t;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_width_t;

   typedef enum logic [1:0] {
      MISALIGNED = 2'd0,
      BUS_ERR    = 2'd1,
      TIMEOUT    = 2'd2
   } lsu_cause_t;

   // Byte accesses are always aligned; halves need an even address, words a
   // multiple of four.
   function automatic logic is_aligned(input mem_width_t width, input logic [1:0] addr_lo);
      logic ok;
      case (width)
         HALF:    ok = ~addr_lo[0];
         WORD:    ok = (addr_lo == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align -- purely combinational byte-lane logic for memory accesses.
//   Store side: st_width/st_addr_lo/st_data -> replicated st_wdata + st_strb.
//   Load side : ld_width/ld_unsigned/ld_addr_lo/ld_rdata -> extended ld_data.
// The two halves are independent so callers may feed them from different
// pipeline points (request inputs vs. registered request state).
// ----------------------------------------------------------------------------
module lsu_align
   import core::*;
(
   input  mem_width_t  st_width,
   input  logic [1:0]  st_addr_lo,
   input  word_t       st_data,
   output word_t       st_wdata,
   output logic [3:0]  st_strb,
   input  mem_width_t  ld_width,
   input  logic        ld_unsigned,
   input  logic [1:0]  ld_addr_lo,
   input  word_t       ld_rdata,
   output word_t       ld_data
);

   word_t ld_shifted;
   logic  ld_sign;

   // Replicating the operand across all lanes lets the strobes alone select
   // the bytes that land in memory.
   always_comb begin
      st_wdata = st_data;
      st_strb  = 4'b1111;
      case (st_width)
         BYTE: begin
            st_wdata = {4{st_data[7:0]}};
            st_strb  = 4'b0001 << st_addr_lo;
         end
         HALF: begin
            st_wdata = {2{st_data[15:0]}};
            st_strb  = 4'b0011 << st_addr_lo;
         end
         default: ;
      endcase
   end

   // Move the addressed byte lane down to bit 0, then extend.
   assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = ld_shifted;
      ld_sign = 1'b0;
      case (ld_width)
         BYTE: begin
            ld_sign = ~ld_unsigned & ld_shifted[7];
            ld_data = {{24{ld_sign}}, ld_shifted[7:0]};
         end
         HALF: begin
            ld_sign = ~ld_unsigned & ld_shifted[15];
            ld_data = {{16{ld_sign}}, ld_shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- rv32 memory-stage load/store unit.
//   req_*  : memory op from execute (valid/ready, one op at a time)
//   flush  : kill the in-flight op's response; blocks acceptance in IDLE
//   rsp_*  : one registered response pulse per accepted, unflushed op
//   bus_*  : single-outstanding valid/ready data bus with byte strobes
//   TIMEOUT: bus cycles without bus_ready before abort (0 = never)
// ----------------------------------------------------------------------------
module lsu
   import core::*;
#(
   parameter int unsigned TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  mem_op_t     req_op,
   input  mem_width_t  req_width,
   input  logic        req_unsigned,
   input  word_t       req_addr,
   input  word_t       req_data,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        rsp_valid,
   output word_t       rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        rsp_fault,
   output lsu_cause_t  rsp_cause,
   output logic        bus_valid,
   output logic        bus_we,
   output word_t       bus_addr,
   output word_t       bus_wdata,
   output logic [3:0]  bus_strb,
   input  logic        bus_ready,
   input  logic        bus_err,
   input  word_t       bus_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_reg;
   word_t       addr_reg;
   word_t       wdata_reg;
   logic        we_reg;
   logic [3:0]  strb_reg;
   mem_width_t  width_reg;
   logic        unsigned_reg;
   logic [4:0]  rd_reg;
   logic        flushed_reg;
   logic [31:0] cnt_reg;

   logic        rsp_valid_reg;
   word_t       rsp_data_reg;
   logic [4:0]  rsp_rd_reg;
   logic        rsp_fault_reg;
   lsu_cause_t  rsp_cause_reg;

   word_t       st_wdata;
   logic [3:0]  st_strb;
   word_t       ld_data;
   logic        accept;
   logic        aligned;
   logic        timed_out;

   lsu_align u_align (
      .st_width    (req_width),
      .st_addr_lo  (req_addr[1:0]),
      .st_data     (req_data),
      .st_wdata    (st_wdata),
      .st_strb     (st_strb),
      .ld_width    (width_reg),
      .ld_unsigned (unsigned_reg),
      .ld_addr_lo  (addr_reg[1:0]),
      .ld_rdata    (bus_rdata),
      .ld_data     (ld_data)
   );

   assign req_ready = (state_reg == S_IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign aligned   = is_aligned(req_width, req_addr[1:0]);

   // Abort on the last allowed waiting cycle so bus_valid is high for exactly
   // TIMEOUT cycles.
   assign timed_out = (TIMEOUT != 0) && !bus_ready && (cnt_reg == TIMEOUT - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         we_reg        <= 1'b0;
         strb_reg      <= 4'b0000;
         width_reg     <= BYTE;
         unsigned_reg  <= 1'b0;
         rd_reg        <= 5'd0;
         flushed_reg   <= 1'b0;
         cnt_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_rd_reg    <= 5'd0;
         rsp_fault_reg <= 1'b0;
         rsp_cause_reg <= MISALIGNED;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  addr_reg     <= req_addr;
                  we_reg       <= (req_op == STORE);
                  wdata_reg    <= st_wdata;
                  strb_reg     <= (req_op == STORE) ? st_strb : 4'b0000;
                  width_reg    <= req_width;
                  unsigned_reg <= req_unsigned;
                  rd_reg       <= req_rd;
                  flushed_reg  <= 1'b0;
                  cnt_reg      <= '0;
                  if (aligned) begin
                     state_reg <= S_BUS;
                  end else begin
                     // Misaligned ops skip the bus entirely.
                     state_reg     <= S_RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_fault_reg <= 1'b1;
                     rsp_cause_reg <= MISALIGNED;
                     rsp_data_reg  <= '0;
                     rsp_rd_reg    <= 5'd0;
                  end
               end
            end
            S_BUS: begin
               // A flush seen at any point of the bus phase kills the response,
               // but the bus transaction itself is allowed to finish.
               if (flush) begin
                  flushed_reg <= 1'b1;
               end
               if (bus_ready || bus_err || timed_out) begin
                  state_reg     <= S_RESP;
                  rsp_valid_reg <= !(flushed_reg || flush);
                  if (bus_err) begin
                     rsp_fault_reg <= 1'b1;
                     rsp_cause_reg <= BUS_ERR;
                     rsp_data_reg  <= '0;
                     rsp_rd_reg    <= 5'd0;
                  end else if (!bus_ready) begin
                     rsp_fault_reg <= 1'b1;
                     rsp_cause_reg <= core::TIMEOUT;
                     rsp_data_reg  <= '0;
                     rsp_rd_reg    <= 5'd0;
                  end else begin
                     rsp_fault_reg <= 1'b0;
                     rsp_cause_reg <= MISALIGNED;
                     rsp_data_reg  <= we_reg ? '0 : ld_data;
                     rsp_rd_reg    <= we_reg ? 5'd0 : rd_reg;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            S_RESP: begin
               // Response fields are only meaningful during the pulse.
               state_reg     <= S_IDLE;
               rsp_valid_reg <= 1'b0;
               rsp_data_reg  <= '0;
               rsp_rd_reg    <= 5'd0;
               rsp_fault_reg <= 1'b0;
               rsp_cause_reg <= MISALIGNED;
            end
            default: begin
               state_reg     <= S_IDLE;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_reg && !flush;
   assign rsp_data  = rsp_data_reg;
   assign rsp_rd    = rsp_rd_reg;
   assign rsp_fault = rsp_fault_reg;
   assign rsp_cause = rsp_cause_reg;

   // bus_valid comes straight from the state register, so an asynchronous
   // reset drops it immediately.
   assign bus_valid = (state_reg == S_BUS);
   assign bus_we    = we_reg;
   assign bus_addr  = {addr_reg[31:2], 2'b00};
   assign bus_wdata = wdata_reg;
   assign bus_strb  = strb_reg;

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. Two instances share all inputs:
// u_dut_a has the timeout disabled, u_dut_t aborts after 3 bus cycles.
// Expected responses are queued per instance when an op is issued and popped
// by a monitor whenever that instance pulses rsp_valid.
// ----------------------------------------------------------------------------
module tb_lsu;

   typedef struct packed {
      logic [31:0]      data;
      logic [4:0]       rd;
      logic             fault;
      core::lsu_cause_t cause;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   core::mem_op_t     req_op;
   core::mem_width_t  req_width;
   logic              req_unsigned;
   core::word_t       req_addr;
   core::word_t       req_data;
   logic [4:0]        req_rd;
   logic              flush;
   logic              bus_ready;
   logic              bus_err;
   core::word_t       bus_rdata;

   logic              req_ready_a, rsp_valid_a, rsp_fault_a, bus_valid_a, bus_we_a;
   core::word_t       rsp_data_a, bus_addr_a, bus_wdata_a;
   logic [4:0]        rsp_rd_a;
   core::lsu_cause_t  rsp_cause_a;
   logic [3:0]        bus_strb_a;

   logic              req_ready_t, rsp_valid_t, rsp_fault_t, bus_valid_t, bus_we_t;
   core::word_t       rsp_data_t, bus_addr_t, bus_wdata_t;
   logic [4:0]        rsp_rd_t;
   core::lsu_cause_t  rsp_cause_t;
   logic [3:0]        bus_strb_t;

   int   n_checks = 0;
   int   n_errors = 0;
   rsp_t exp_a[$];
   rsp_t exp_t[$];
   rsp_t mon_a;
   rsp_t mon_t;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(0)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_a), .req_op(req_op),
      .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_data(req_data), .req_rd(req_rd), .flush(flush),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_rd(rsp_rd_a),
      .rsp_fault(rsp_fault_a), .rsp_cause(rsp_cause_a),
      .bus_valid(bus_valid_a), .bus_we(bus_we_a), .bus_addr(bus_addr_a),
      .bus_wdata(bus_wdata_a), .bus_strb(bus_strb_a),
      .bus_ready(bus_ready), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   lsu #(.TIMEOUT(3)) u_dut_t (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_t), .req_op(req_op),
      .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_data(req_data), .req_rd(req_rd), .flush(flush),
      .rsp_valid(rsp_valid_t), .rsp_data(rsp_data_t), .rsp_rd(rsp_rd_t),
      .rsp_fault(rsp_fault_t), .rsp_cause(rsp_cause_t),
      .bus_valid(bus_valid_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
      .bus_wdata(bus_wdata_t), .bus_strb(bus_strb_t),
      .bus_ready(bus_ready), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard monitors: every response pulse must match the oldest queued
   // expectation; a pulse with nothing queued is an error.
   always @(negedge clk) begin
      if (rsp_valid_a) begin
         if (exp_a.size() == 0) begin
            check_val("a_unexpected_rsp", 32'(rsp_valid_a), 32'd0);
         end else begin
            mon_a = exp_a.pop_front();
            check_val("a_rsp_data",  rsp_data_a,         mon_a.data);
            check_val("a_rsp_rd",    32'(rsp_rd_a),      32'(mon_a.rd));
            check_val("a_rsp_fault", 32'(rsp_fault_a),   32'(mon_a.fault));
            if (mon_a.fault)
               check_val("a_rsp_cause", 32'(rsp_cause_a), 32'(mon_a.cause));
            $display("rsp a: data=%08h rd=%0d fault=%0d cause=%0d", rsp_data_a, rsp_rd_a, rsp_fault_a, rsp_cause_a);
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_valid_t) begin
         if (exp_t.size() == 0) begin
            check_val("t_unexpected_rsp", 32'(rsp_valid_t), 32'd0);
         end else begin
            mon_t = exp_t.pop_front();
            check_val("t_rsp_data",  rsp_data_t,         mon_t.data);
            check_val("t_rsp_rd",    32'(rsp_rd_t),      32'(mon_t.rd));
            check_val("t_rsp_fault", 32'(rsp_fault_t),   32'(mon_t.fault));
            if (mon_t.fault)
               check_val("t_rsp_cause", 32'(rsp_cause_t), 32'(mon_t.cause));
         end
      end
   end

   // Issue one op, serve the bus after lat waiting cycles, and check the bus
   // side and response timing. flush_k >= 0 pulses flush in that bus cycle.
   task automatic do_op(
      input core::mem_op_t    op,
      input core::mem_width_t w,
      input logic             uns,
      input logic [31:0]      addr,
      input logic [31:0]      data,
      input logic [4:0]       rd,
      input logic [31:0]      rdata,
      input int               lat,
      input logic             err,
      input int               flush_k,
      input logic [31:0]      exp_wdata,
      input logic [3:0]       exp_strb,
      input logic [31:0]      exp_data,
      input logic [4:0]       exp_rd,
      input logic             exp_fault,
      input core::lsu_cause_t exp_cause
   );
      rsp_t ea;
      rsp_t et;
      logic misal;
      logic live;
      misal = exp_fault && (exp_cause == core::MISALIGNED);
      live  = (flush_k < 0);
      ea = '{data: exp_data, rd: exp_rd, fault: exp_fault, cause: exp_cause};
      et = ea;
      if (!misal && lat >= 3)
         et = '{data: 32'd0, rd: 5'd0, fault: 1'b1, cause: core::TIMEOUT};
      if (live) begin
         exp_a.push_back(ea);
         exp_t.push_back(et);
      end
      $display("op: %s w=%0d uns=%0d addr=%08h data=%08h lat=%0d err=%0d flush_k=%0d",
               (op == core::STORE) ? "ST" : "LD", w, uns, addr, data, lat, err, flush_k);

      @(negedge clk);
      check_val("req_ready", 32'(req_ready_a), 32'd1);
      req_valid    = 1'b1;
      req_op       = op;
      req_width    = w;
      req_unsigned = uns;
      req_addr     = addr;
      req_data     = data;
      req_rd       = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_data  = 32'h5555_5555;

      if (misal) begin
         @(negedge clk);
         check_val("misal_bus_valid", 32'(bus_valid_a), 32'd0);
         check_val("misal_rsp_valid", 32'(rsp_valid_a), 32'd1);
      end else begin
         for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            flush = (k == flush_k);
            check_val("bus_valid", 32'(bus_valid_a), 32'd1);
            check_val("bus_addr",  bus_addr_a, {addr[31:2], 2'b00});
            check_val("bus_strb",  32'(bus_strb_a), 32'(exp_strb));
            check_val("bus_we",    32'(bus_we_a), 32'(op == core::STORE));
            if (op == core::STORE)
               check_val("bus_wdata", bus_wdata_a, exp_wdata);
            if (lat >= 3)
               check_val("to_bus_valid", 32'(bus_valid_t), 32'(k < 3));
            if (k == lat) begin
               bus_ready = 1'b1;
               bus_err   = err;
               bus_rdata = rdata;
            end
            @(posedge clk);
            #1;
            bus_ready = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = 32'h0;
         end
         @(negedge clk);
         flush = 1'b0;
         check_val(live ? "rsp_pulse" : "flush_suppress", 32'(rsp_valid_a), 32'(live));
      end
      @(negedge clk);
      check_val("rsp_single_pulse", 32'(rsp_valid_a), 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_op       = core::LOAD;
      req_width    = core::BYTE;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_data     = 32'h0;
      req_rd       = 5'd0;
      flush        = 1'b0;
      bus_ready    = 1'b0;
      bus_err      = 1'b0;
      bus_rdata    = 32'h0;

      repeat (2) @(negedge clk);
      check_val("rst_req_ready", 32'(req_ready_a), 32'd1);
      check_val("rst_bus_valid", 32'(bus_valid_a), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
      check_val("rst_bus_strb",  32'(bus_strb_a), 32'd0);
      check_val("rst_bus_addr",  bus_addr_a, 32'd0);
      check_val("rst_rsp_data",  rsp_data_a, 32'd0);
      check_val("rst_rsp_fault", 32'(rsp_fault_a), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      //     op          width       uns  addr          data          rd     rdata         lat err  flk  wdata         strb     rsp_data      rd     flt  cause
      do_op(core::STORE, core::WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 32'h0,        0, 1'b0, -1, 32'hDEAD_BEEF, 4'b1111, 32'h0,        5'd0, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::BYTE, 1'b0, 32'h0000_0103, 32'h0,         5'd5, 32'h80FF_0000, 0, 1'b0, -1, 32'h0,         4'b0000, 32'hFFFF_FF80, 5'd5, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::BYTE, 1'b1, 32'h0000_0103, 32'h0,         5'd5, 32'h80FF_0000, 0, 1'b0, -1, 32'h0,         4'b0000, 32'h0000_0080, 5'd5, 1'b0, core::MISALIGNED);
      do_op(core::STORE, core::HALF, 1'b0, 32'h0000_0102, 32'h0000_1234, 5'd2, 32'h0,        0, 1'b0, -1, 32'h1234_1234, 4'b1100, 32'h0,        5'd0, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::HALF, 1'b0, 32'h0000_0101, 32'h0,         5'd6, 32'h0,        0, 1'b0, -1, 32'h0,         4'b0000, 32'h0,        5'd0, 1'b1, core::MISALIGNED);
      do_op(core::LOAD,  core::WORD, 1'b0, 32'h0000_0104, 32'h0,         5'd9, 32'hCAFE_F00D, 5, 1'b0, -1, 32'h0,         4'b0000, 32'hCAFE_F00D, 5'd9, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::WORD, 1'b0, 32'h0000_0108, 32'h0,         5'd3, 32'h1111_1111, 0, 1'b1, -1, 32'h0,         4'b0000, 32'h0,        5'd0, 1'b1, core::BUS_ERR);
      do_op(core::LOAD,  core::WORD, 1'b0, 32'h0000_010C, 32'h0,         5'd8, 32'h2222_2222, 2, 1'b0,  0, 32'h0,         4'b0000, 32'h2222_2222, 5'd8, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::HALF, 1'b0, 32'h0000_0100, 32'h0,         5'd4, 32'h1234_ABCD, 0, 1'b0, -1, 32'h0,         4'b0000, 32'hFFFF_ABCD, 5'd4, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::HALF, 1'b1, 32'h0000_0102, 32'h0,         5'd4, 32'h8001_0000, 1, 1'b0, -1, 32'h0,         4'b0000, 32'h0000_8001, 5'd4, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::HALF, 1'b0, 32'h0000_0102, 32'h0,         5'd1, 32'h7FFF_0000, 0, 1'b0, -1, 32'h0,         4'b0000, 32'h0000_7FFF, 5'd1, 1'b0, core::MISALIGNED);
      do_op(core::STORE, core::BYTE, 1'b0, 32'h0000_0101, 32'h1234_56A5, 5'd2, 32'h0,        0, 1'b0, -1, 32'hA5A5_A5A5, 4'b0010, 32'h0,        5'd0, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::WORD, 1'b0, 32'h0000_0102, 32'h0,         5'd2, 32'h0,        0, 1'b0, -1, 32'h0,         4'b0000, 32'h0,        5'd0, 1'b1, core::MISALIGNED);
      do_op(core::STORE, core::WORD, 1'b0, 32'h0000_0200, 32'h0BAD_F00D, 5'd2, 32'h0,        3, 1'b0, -1, 32'h0BAD_F00D, 4'b1111, 32'h0,        5'd0, 1'b0, core::MISALIGNED);
      do_op(core::LOAD,  core::BYTE, 1'b1, 32'h0000_0111, 32'h0,         5'd31, 32'h0000_C300, 1, 1'b0, -1, 32'h0,        4'b0000, 32'h0000_00C3, 5'd31, 1'b0, core::MISALIGNED);

      // flush while idle holds off acceptance
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_val("flush_idle_ready", 32'(req_ready_a), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_val("flush_idle_release", 32'(req_ready_a), 32'd1);

      // reset in the middle of a bus transaction
      $display("op: LD w=2 addr=00000300 reset mid-bus");
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = core::LOAD;
      req_width = core::WORD;
      req_addr  = 32'h0000_0300;
      req_rd    = 5'd12;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_val("pre_rst_bus_valid", 32'(bus_valid_a), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_val("async_rst_bus_valid_a", 32'(bus_valid_a), 32'd0);
      check_val("async_rst_bus_valid_t", 32'(bus_valid_t), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_req_ready", 32'(req_ready_a), 32'd1);
      check_val("post_rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
      repeat (4) @(negedge clk);

      check_val("a_queue_drained", 32'(exp_a.size()), 32'd0);
      check_val("t_queue_drained", 32'(exp_t.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the rv32 core's memory stage, directly downstream of the execute-stage ALU. It takes the ALU-computed effective address plus the store operand. It checks alignment, drives a single-outstanding valid/ready data-bus transaction with byte strobes, then aligns and sign/zero-extends load data. It returns one response per accepted request to writeback, and back-pressures the pipeline while busy.

## Interface
- TIMEOUT, default 0: bus cycles without bus_ready before abort; 0 disables the timeout.
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  in  core::mem_op_t  LOAD or STORE.
- req_width  in  core::mem_width_t  BYTE, HALF or WORD.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  core::word_t  effective address (ALU out).
- req_data  in  core::word_t  store operand (rs2).
- req_rd  in  5  load destination register.
- flush  in  1  kill the in-flight op's response.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  core::word_t  extended load data; 0 for stores and faults.
- rsp_rd  out  5  req_rd for loads; 0 for stores and faults.
- rsp_fault  out  1  op faulted.
- rsp_cause  out  core::lsu_cause_t  MISALIGNED, BUS_ERR or TIMEOUT; valid when rsp_fault=1.
- bus_valid, bus_we  out  1  bus request and write enable.
- bus_addr  out  core::word_t  word address {addr[31:2],2'b00}.
- bus_wdata  out  core::word_t  replicated store data.
- bus_strb  out  4  byte enables; 0000 for loads.
- bus_ready, bus_err  in  1  bus completion and error.
- bus_rdata  in  core::word_t  read data, sampled on bus_ready.

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE -> BUS on accept if the op is aligned.
  - IDLE -> RESP on accept if the op is misaligned; rsp_cause=MISALIGNED, no bus cycle.
  - BUS -> RESP on bus_ready, bus_err or timeout.
  - RESP -> IDLE unconditionally.
- Alignment rules:
  - BYTE: always aligned.
  - HALF: requires addr[0]=0.
  - WORD: requires addr[1:0]=00.
- Store lane mapping:
  - BYTE: wdata={4{data[7:0]}}, strb=0001<<addr[1:0].
  - HALF: wdata={2{data[15:0]}}, strb=0011<<addr[1:0].
  - WORD: wdata=data, strb=1111.
- Load extraction:
  - Shift bus_rdata right by 8*addr[1:0].
  - Take 8, 16 or 32 bits and sign-extend unless req_unsigned.
- bus_valid=1 throughout BUS. bus_addr, bus_we, bus_wdata and bus_strb are registered at accept and held stable until completion.
- bus_err together with bus_ready: the error wins; rsp_fault=1, rsp_cause=BUS_ERR, rsp_data=0.
- Timeout: a counter clears at accept and increments each BUS cycle without bus_ready.
  - At TIMEOUT cycles the unit drops bus_valid and goes to RESP with cause TIMEOUT.
  - This is the only case where bus_valid falls without a handshake.
- flush:
  - In IDLE, flush blocks acceptance (req_ready=0).
  - In BUS, the bus transaction still completes, but the response is suppressed.
  - In RESP, rsp_valid is forced to 0.
  - A suppressed response never reaches writeback.
- Reset values: state=IDLE, req_ready=1, and all of rsp_* and bus_* are 0. Reset mid-BUS drops bus_valid asynchronously and emits no response.

## Timing
- Accept in cycle N. bus_valid is high from N+1. With bus_ready at N+1, rsp_valid pulses at N+2.
- Misaligned op: rsp_valid at N+1.
- Next accept is no earlier than the cycle after RESP: minimum 3 cycles per bus op, 2 per fault.
- rsp_* outputs are registered and valid only during the rsp_valid cycle.
- req_ready is combinational from state and flush; there is no combinational path from req_* to bus_*.

## Structure
- In package core:
  - mem_op_t {LOAD, STORE}.
  - mem_width_t {BYTE, HALF, WORD}.
  - lsu_cause_t {MISALIGNED, BUS_ERR, TIMEOUT}.
  - word_t (existing).
- Sub-module lsu_align is natural: combinational store lane/strobe generation plus load extract/extend. It is shared with a future instruction-fetch or AMO path.
- FSM, timeout counter and request registers live in lsu.

## Test plan
- SW addr=0x100, data=0xDEADBEEF, bus_ready at the first cycle -> bus_addr=0x100, strb=1111, we=1; rsp_valid 2 cycles after accept with rsp_rd=0 and no fault.
- LB addr=0x103, bus_rdata=0x80FF_0000 (signed) -> rsp_data=0xFFFFFF80. Same case with LBU -> 0x00000080.
- SH addr=0x102, data=0x1234 -> bus_wdata=0x12341234, strb=1100. LH addr=0x101 -> no bus_valid; rsp_fault=1, cause=MISALIGNED, rsp_valid at N+1.
- Load with bus_ready delayed 5 cycles (TIMEOUT=0) -> bus_addr/strb stable throughout, one rsp_valid. Repeat with TIMEOUT=3 -> bus_valid drops after 3 cycles, cause=TIMEOUT.
- bus_err with bus_ready -> cause=BUS_ERR, rsp_data=0, rsp_rd=0.
- Boundary cases:
  - flush during BUS -> the transaction completes and rsp_valid stays 0.
  - reset asserted mid-BUS -> bus_valid=0 immediately, req_ready=1 after release, no response.
